// File: rtl/vga_line_fetch_if.sv
// SDRAM arbiter read channel used by the VGA line fetcher.
// The master drives burst requests; the slave returns the grant and the read beats.
interface vga_line_fetch_if;
  logic        sdram_request;
  logic [25:0] sdram_address;
  logic [3:0]  sdram_burst;
  logic        sdram_grant;
  logic        sdram_rvalid;
  logic [31:0] sdram_rdata;

  modport master (
    output sdram_request, sdram_address, sdram_burst,
    input  sdram_grant, sdram_rvalid, sdram_rdata
  );

  modport slave (
    input  sdram_request, sdram_address, sdram_burst,
    output sdram_grant, sdram_rvalid, sdram_rdata
  );
endinterface

// File: rtl/vga_line_fetch.sv
// Prefetches one display line per line_start into a ping-pong buffer and serves pixels by offset.
// Define VGA_FETCH_STATS_EN to add a saturating underrun_count_o output.
module vga_line_fetch #(
  parameter int BURST_WORDS = 8,
  parameter int MAX_LINE    = 640
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   line_start_i,
  input  logic [25:0]            fetch_address_i,
  input  logic [9:0]             fetch_length_i,
  vga_line_fetch_if.master       sdram,
  input  logic [9:0]             rd_index_i,
  output logic [7:0]             rd_data_o,
  output logic                   fetch_busy_o,
  output logic                   underrun_o
`ifdef VGA_FETCH_STATS_EN
  ,
  output logic [15:0]            underrun_count_o
`endif
);

  localparam int DEPTH = MAX_LINE / 4 + 1;
  localparam int PW    = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, REQ, DATA, DRAIN} state_t;

  state_t        state_q, state_d;
  logic [25:0]   wordAddr_q, wordAddr_d;
  logic [8:0]    words_q, words_d;
  logic [3:0]    beatCnt_q, beatCnt_d;
  logic [PW-1:0] wrPtr_q, wrPtr_d;
  logic [1:0]    offFill_q, offFill_d;
  logic [1:0]    offDisp_q, offDisp_d;
  logic          dispSel_q, dispSel_d;
  logic          request_q, request_d;
  logic [25:0]   address_q, address_d;
  logic [3:0]    burst_q, burst_d;
  logic          underrun_q, underrun_d;
  logic [7:0]    rdData_q;
  logic          wrEn;

  logic [31:0] mem0 [DEPTH];
  logic [31:0] mem1 [DEPTH];

  logic [10:0] newSum;
  logic [8:0]  newWords;
  logic [25:0] newWordAddr;
  logic [8:0]  wordsAfter;
  logic [25:0] addrAfter;
  logic [3:0]  remaining;

  assign newSum      = {1'b0, fetch_length_i} + {9'd0, fetch_address_i[1:0]} + 11'd3;
  assign newWords    = newSum[10:2];
  assign newWordAddr = {fetch_address_i[25:2], 2'b00};
  assign wordsAfter  = words_q - {5'd0, burst_q};
  assign addrAfter   = wordAddr_q + {20'd0, burst_q, 2'b00};
  assign remaining   = beatCnt_q - {3'd0, sdram.sdram_rvalid};

  function automatic logic [3:0] burstFor(input logic [8:0] w);
    return (w > 9'(BURST_WORDS)) ? 4'(BURST_WORDS) : w[3:0];
  endfunction

  // Next-state logic: the old state's beat handling runs first, then a line_start overrides
  // the line parameters and redirects the FSM so a coincident beat still counts for the old burst.
  always_comb begin
    state_d    = state_q;
    wordAddr_d = wordAddr_q;
    words_d    = words_q;
    beatCnt_d  = beatCnt_q;
    wrPtr_d    = wrPtr_q;
    offFill_d  = offFill_q;
    offDisp_d  = offDisp_q;
    dispSel_d  = dispSel_q;
    request_d  = request_q;
    address_d  = address_q;
    burst_d    = burst_q;
    underrun_d = 1'b0;
    wrEn       = 1'b0;

    case (state_q)
      IDLE: ;
      REQ: begin
        if (!request_q) begin
          request_d = 1'b1;
          address_d = wordAddr_q;
          burst_d   = burstFor(words_q);
        end else if (sdram.sdram_grant) begin
          request_d = 1'b0;
          beatCnt_d = burst_q;
          state_d   = DATA;
        end
      end
      DATA: begin
        if (sdram.sdram_rvalid) begin
          wrEn      = 1'b1;
          wrPtr_d   = wrPtr_q + PW'(1);
          beatCnt_d = beatCnt_q - 4'd1;
          if (beatCnt_q == 4'd1) begin
            words_d    = wordsAfter;
            wordAddr_d = addrAfter;
            if (wordsAfter != 9'd0) begin
              state_d   = REQ;
              request_d = 1'b1;
              address_d = addrAfter;
              burst_d   = burstFor(wordsAfter);
            end else begin
              state_d = IDLE;
            end
          end
        end
      end
      DRAIN: begin
        if (sdram.sdram_rvalid) begin
          beatCnt_d = beatCnt_q - 4'd1;
          if (beatCnt_q == 4'd1) begin
            if (words_q != 9'd0) begin
              state_d   = REQ;
              request_d = 1'b1;
              address_d = wordAddr_q;
              burst_d   = burstFor(words_q);
            end else begin
              state_d = IDLE;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (line_start_i) begin
      dispSel_d  = ~dispSel_q;
      offDisp_d  = offFill_q;
      offFill_d  = fetch_address_i[1:0];
      wordAddr_d = newWordAddr;
      words_d    = newWords;
      wrPtr_d    = '0;
      underrun_d = (state_q != IDLE);

      // A burst already granted must be drained before the new line may request.
      if ((state_q == REQ && request_q && sdram.sdram_grant) ||
          ((state_q == DATA || state_q == DRAIN) && remaining != 4'd0)) begin
        state_d   = DRAIN;
        request_d = 1'b0;
        beatCnt_d = (state_q == REQ) ? burst_q : remaining;
      end else if (state_q == REQ) begin
        request_d = 1'b0;
        state_d   = (newWords != 9'd0) ? REQ : IDLE;
      end else if (newWords != 9'd0) begin
        state_d   = REQ;
        request_d = 1'b1;
        address_d = newWordAddr;
        burst_d   = burstFor(newWords);
      end else begin
        state_d   = IDLE;
        request_d = 1'b0;
      end
    end
  end

  // Control and output registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      wordAddr_q <= '0;
      words_q    <= '0;
      beatCnt_q  <= '0;
      wrPtr_q    <= '0;
      offFill_q  <= '0;
      offDisp_q  <= '0;
      dispSel_q  <= 1'b0;
      request_q  <= 1'b0;
      address_q  <= '0;
      burst_q    <= '0;
      underrun_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wordAddr_q <= wordAddr_d;
      words_q    <= words_d;
      beatCnt_q  <= beatCnt_d;
      wrPtr_q    <= wrPtr_d;
      offFill_q  <= offFill_d;
      offDisp_q  <= offDisp_d;
      dispSel_q  <= dispSel_d;
      request_q  <= request_d;
      address_q  <= address_d;
      burst_q    <= burst_d;
      underrun_q <= underrun_d;
    end
  end

  // The fill buffer is always the one not being displayed.
  always_ff @(posedge clock) begin
    if (wrEn) begin
      if (dispSel_q) mem0[wrPtr_q] <= sdram.sdram_rdata;
      else           mem1[wrPtr_q] <= sdram.sdram_rdata;
    end
  end

  logic [10:0] rdSum;
  logic [8:0]  rdWord;
  logic [31:0] rdWordData;
  logic [7:0]  rdByte;

  always_comb begin
    rdSum      = {1'b0, rd_index_i} + {9'd0, offDisp_q};
    rdWord     = rdSum[10:2];
    rdWordData = '0;
    if (rdWord < 9'(DEPTH)) begin
      rdWordData = dispSel_q ? mem1[rdWord[PW-1:0]] : mem0[rdWord[PW-1:0]];
    end
    rdByte = 8'(rdWordData >> {rdSum[1:0], 3'b000});
  end

  always_ff @(posedge clock) begin
    if (reset) rdData_q <= '0;
    else       rdData_q <= rdByte;
  end

`ifdef VGA_FETCH_STATS_EN
  logic [15:0] urCount_q;

  always_ff @(posedge clock) begin
    if (reset)                                   urCount_q <= '0;
    else if (underrun_q && urCount_q != 16'hFFFF) urCount_q <= urCount_q + 16'd1;
  end

  assign underrun_count_o = urCount_q;
`endif

  assign sdram.sdram_request = request_q;
  assign sdram.sdram_address = address_q;
  assign sdram.sdram_burst   = burst_q;
  assign rd_data_o           = rdData_q;
  assign fetch_busy_o        = (state_q != IDLE);
  assign underrun_o          = underrun_q;

endmodule

// File: tb/tb_vga_line_fetch.sv
// Scoreboard bench for vga_line_fetch: a behavioural SDRAM answers requests, a monitor
// pops expected bursts and pixels from queues filled by the stimulus.
module tb_vga_line_fetch;
  logic        clock = 1'b0;
  logic        reset;
  logic        lineStart;
  logic [25:0] fetchAddress;
  logic [9:0]  fetchLength;
  logic [9:0]  rdIndex;
  logic [7:0]  rdData;
  logic        fetchBusy;
  logic        underrun;
`ifdef VGA_FETCH_STATS_EN
  logic [15:0] underrunCount;
`endif

  vga_line_fetch_if sb ();

  vga_line_fetch dut (
    .clock           (clock),
    .reset           (reset),
    .line_start_i    (lineStart),
    .fetch_address_i (fetchAddress),
    .fetch_length_i  (fetchLength),
    .sdram           (sb),
    .rd_index_i      (rdIndex),
    .rd_data_o       (rdData),
    .fetch_busy_o    (fetchBusy),
    .underrun_o      (underrun)
`ifdef VGA_FETCH_STATS_EN
    ,
    .underrun_count_o(underrunCount)
`endif
  );

  always #4 clock = ~clock;

  int checks = 0;
  int passes = 0;

  logic [29:0] reqQ[$];
  logic [17:0] rdQ[$];
  logic        rdIssue = 1'b0;
  logic        rdPendingM = 1'b0;

  logic        grantEnable = 1'b1;
  logic        corrupt = 1'b0;
  int          beatsSent = 0;

  function automatic logic [7:0] byteAt(input logic [25:0] a);
    return (a[7:0] ^ a[15:8]) + 8'h11;
  endfunction

  function automatic logic [31:0] wordAt(input logic [25:0] a);
    return {byteAt(a + 26'd3), byteAt(a + 26'd2), byteAt(a + 26'd1), byteAt(a)};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Behavioural SDRAM: grant on the second request cycle, then back-to-back beats.
  initial begin
    int grantCnt;
    int beatsLeft;
    logic [25:0] beatAddr;
    grantCnt = 0;
    beatsLeft = 0;
    beatAddr = '0;
    sb.sdram_grant = 1'b0;
    sb.sdram_rvalid = 1'b0;
    sb.sdram_rdata = '0;
    forever begin
      @(posedge clock);
      #1;
      sb.sdram_grant = 1'b0;
      sb.sdram_rvalid = 1'b0;
      if (beatsLeft > 0) begin
        sb.sdram_rvalid = 1'b1;
        sb.sdram_rdata = wordAt(beatAddr) ^ (corrupt ? 32'hFFFF_FFFF : 32'h0);
        beatAddr = beatAddr + 26'd4;
        beatsLeft--;
        beatsSent++;
      end else if (sb.sdram_request && grantEnable) begin
        grantCnt++;
        if (grantCnt == 2) begin
          sb.sdram_grant = 1'b1;
          beatsLeft = int'(sb.sdram_burst);
          beatAddr = sb.sdram_address;
          grantCnt = 0;
        end
      end else begin
        grantCnt = 0;
      end
    end
  end

  // Monitor: accepted requests and registered pixel reads are checked against the queues.
  always @(negedge clock) begin
    logic [29:0] expReq;
    logic [17:0] expRd;
    if (rdPendingM) begin
      if (rdQ.size() == 0) begin
        checkOutput("rd_data unexpected", {24'd0, rdData}, 32'hDEAD);
      end else begin
        expRd = rdQ.pop_front();
        checkOutput($sformatf("rd_data[%0d]", expRd[17:8]), {24'd0, rdData}, {24'd0, expRd[7:0]});
      end
    end
    rdPendingM = rdIssue;
    if (sb.sdram_request && sb.sdram_grant) begin
      if (reqQ.size() == 0) begin
        checkOutput("request unexpected", {sb.sdram_address, sb.sdram_burst}, 32'hDEAD);
      end else begin
        expReq = reqQ.pop_front();
        checkOutput("request addr/burst", {2'b00, sb.sdram_address, sb.sdram_burst}, {2'b00, expReq});
      end
    end
  end

  task automatic applyStimulus(input logic [25:0] a, input logic [9:0] l);
    @(posedge clock);
    #1;
    fetchAddress = a;
    fetchLength = l;
    lineStart = 1'b1;
    @(posedge clock);
    #1;
    lineStart = 1'b0;
  endtask

  task automatic readLine(input logic [25:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
      rdIndex = 10'(i);
      rdIssue = 1'b1;
      rdQ.push_back({10'(i), byteAt(base + 26'(i))});
    end
    @(posedge clock);
    #1;
    rdIssue = 1'b0;
    @(posedge clock);
    @(posedge clock);
  endtask

  task automatic waitIdle(input string name);
    int n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (fetchBusy && n < 300);
    checkOutput({name, " busy dropped"}, {31'd0, fetchBusy}, 32'd0);
  endtask

  task automatic waitBeats(input int base, input int target, input string name);
    int n = 0;
    do begin
      @(posedge clock);
      #2;
      n++;
    end while (beatsSent - base < target && n < 100);
    checkOutput({name, " beats seen"}, beatsSent - base, target);
  endtask

  initial begin
    int base;
    int sawReq;
    reset = 1'b1;
    lineStart = 1'b0;
    fetchAddress = '0;
    fetchLength = '0;
    rdIndex = '0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    checkOutput("reset request", {31'd0, sb.sdram_request}, 0);
    checkOutput("reset address", {6'd0, sb.sdram_address}, 0);
    checkOutput("reset burst", {28'd0, sb.sdram_burst}, 0);
    checkOutput("reset rd_data", {24'd0, rdData}, 0);
    checkOutput("reset busy", {31'd0, fetchBusy}, 0);
    checkOutput("reset underrun", {31'd0, underrun}, 0);
    @(posedge clock);
    #1;
    reset = 1'b0;

    $display("[TB] line of 40 pixels at 0x100");
    reqQ.push_back({26'h100, 4'd8});
    reqQ.push_back({26'h120, 4'd2});
    base = beatsSent;
    applyStimulus(26'h100, 10'd40);
    waitIdle("line 0x100");
    checkOutput("line 0x100 beat total", beatsSent - base, 10);

    $display("[TB] unaligned line at 0x103, reading back line 0x100");
    reqQ.push_back({26'h100, 4'd2});
    applyStimulus(26'h103, 10'd4);
    @(negedge clock);
    checkOutput("no underrun after complete fetch", {31'd0, underrun}, 0);
    readLine(26'h100, 40);
    waitIdle("line 0x103");

    $display("[TB] zero-length line, reading back line 0x103");
    applyStimulus(26'h0, 10'd0);
    sawReq = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      if (sb.sdram_request || fetchBusy) sawReq = 1;
    end
    checkOutput("zero length stays idle", sawReq, 0);
    readLine(26'h103, 4);

    $display("[TB] underrun while waiting for grant");
    grantEnable = 1'b0;
    applyStimulus(26'h1000, 10'd16);
    @(negedge clock);
    checkOutput("no underrun from idle", {31'd0, underrun}, 0);
    checkOutput("request raised 0x1000", {31'd0, sb.sdram_request}, 1);
    repeat (4) @(negedge clock);
    applyStimulus(26'h2000, 10'd8);
    @(negedge clock);
    checkOutput("underrun pulse in REQ", {31'd0, underrun}, 1);
    checkOutput("request dropped", {31'd0, sb.sdram_request}, 0);
    @(negedge clock);
    checkOutput("underrun one cycle", {31'd0, underrun}, 0);
    checkOutput("request re-raised", {31'd0, sb.sdram_request}, 1);
    checkOutput("request new address", {6'd0, sb.sdram_address}, 32'h2000);
    reqQ.push_back({26'h2000, 4'd2});
    grantEnable = 1'b1;
    waitIdle("line 0x2000");

    $display("[TB] underrun mid-burst with drain");
    grantEnable = 1'b0;
    reqQ.push_back({26'h3000, 4'd8});
    applyStimulus(26'h3000, 10'd32);
    readLine(26'h2000, 8);
    base = beatsSent;
    grantEnable = 1'b1;
    waitBeats(base, 3, "pre-underrun");
    fetchAddress = 26'h4000;
    fetchLength = 10'd4;
    lineStart = 1'b1;
    corrupt = 1'b1;
    reqQ.push_back({26'h4000, 4'd1});
    @(posedge clock);
    #1;
    lineStart = 1'b0;
    @(negedge clock);
    checkOutput("underrun pulse in DATA", {31'd0, underrun}, 1);
    waitBeats(base, 8, "drained burst");
    corrupt = 1'b0;
    waitIdle("line 0x4000");
    checkOutput("drain plus new line beats", beatsSent - base, 9);
    readLine(26'h3000, 12);

    $display("[TB] reset in the middle of a burst");
    grantEnable = 1'b0;
    reqQ.push_back({26'h5000, 4'd8});
    applyStimulus(26'h5000, 10'd32);
    readLine(26'h4000, 4);
    base = beatsSent;
    grantEnable = 1'b1;
    waitBeats(base, 2, "pre-reset");
`ifdef VGA_FETCH_STATS_EN
    checkOutput("underrun_count before reset", {16'd0, underrunCount}, 2);
`endif
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    @(negedge clock);
    checkOutput("mid-burst reset request", {31'd0, sb.sdram_request}, 0);
    checkOutput("mid-burst reset busy", {31'd0, fetchBusy}, 0);
    checkOutput("mid-burst reset rd_data", {24'd0, rdData}, 0);
`ifdef VGA_FETCH_STATS_EN
    checkOutput("underrun_count after reset", {16'd0, underrunCount}, 0);
`endif
    waitBeats(base, 8, "trailing beats");
    repeat (3) @(negedge clock);
    checkOutput("trailing beats ignored busy", {31'd0, fetchBusy}, 0);
    checkOutput("trailing beats ignored request", {31'd0, sb.sdram_request}, 0);

    $display("[TB] recovery after reset");
    reqQ.push_back({26'h600, 4'd2});
    applyStimulus(26'h600, 10'd8);
    waitIdle("line 0x600");
    applyStimulus(26'h0, 10'd0);
    readLine(26'h600, 8);

    checkOutput("request queue drained", reqQ.size(), 0);
    checkOutput("read queue drained", rdQ.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
